// File: rtl/ldst_issue_ctrl.sv
// ldst_issue_ctrl: in-order load/store issue controller between dispatch
// and the data cache. Ops are buffered in a DEPTH-entry FIFO, issued one
// at a time over a valid/ready request port, and completed to the ROB by
// tag. A single load may be outstanding; flush kills queued and in-flight
// work and drains the orphaned load response.
// Optional build macro: LDST_MISALIGN_TRAP_EN traps misaligned H/W ops at
// the queue head instead of sending them to the D$.
module ldst_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [3:0]       in_ld_st_type,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             dc_req_valid,
    input  logic             dc_req_ready,
    output logic             dc_req_store,
    output logic [XLEN-1:0]  dc_req_addr,
    output logic [XLEN-1:0]  dc_req_data,
    output logic [1:0]       dc_req_size,
    output logic             dc_req_sext,
    output logic [TAG_W-1:0] dc_req_tag,
    input  logic             dc_resp_valid,
    input  logic [TAG_W-1:0] dc_resp_tag,
    input  logic [XLEN-1:0]  dc_resp_data,
    output logic             cmp_valid,
    output logic [TAG_W-1:0] cmp_tag,
    output logic [XLEN-1:0]  cmp_data,
    output logic             cmp_store,
    output logic             cmp_exc,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Entry layout: {store, sext, size[1:0], tag, addr, data}
    localparam int ENT_W = 4 + TAG_W + 2 * XLEN;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       state_reg;
    logic [TAG_W-1:0] ld_tag_reg;

    logic             cmp_valid_reg, cmp_store_reg, cmp_exc_reg;
    logic [TAG_W-1:0] cmp_tag_reg;
    logic [XLEN-1:0]  cmp_data_reg;

    logic             in_store, in_sext;
    logic [1:0]       in_size;
    logic [ENT_W-1:0] in_entry, head_entry;
    logic             head_store, head_sext, head_mis;
    logic [1:0]       head_size;
    logic [TAG_W-1:0] head_tag;
    logic [XLEN-1:0]  head_addr, head_data;
    logic             head_avail, issue_fire, trap_fire, push, pop, resp_match;
    logic             unused_bits;

    // Decode at enqueue so the head only carries what the D$ needs;
    // the illegal size encoding 3 is folded into a word access.
    assign in_store = in_opcode[3];
    assign in_sext  = ~in_ld_st_type[2];
    assign in_size  = (in_ld_st_type[1:0] == 2'd3) ? 2'd2 : in_ld_st_type[1:0];
    assign in_entry = {in_store, in_sext, in_size, in_tag, in_rs1, in_rs2};
    assign unused_bits = ^{in_opcode[4], in_opcode[2:0], in_ld_st_type[3]};

    assign head_entry = mem[rd_ptr_reg];
    assign {head_store, head_sext, head_size, head_tag, head_addr, head_data} = head_entry;

`ifdef LDST_MISALIGN_TRAP_EN
    assign head_mis = ((head_size == 2'd1) && head_addr[0]) ||
                      ((head_size == 2'd2) && (head_addr[1:0] != 2'b00));
`else
    assign head_mis = 1'b0;
`endif

    assign head_avail = (state_reg == IDLE) && (count_reg != '0);
    assign in_ready   = (count_reg < CNT_W'(DEPTH)) && (state_reg != DRAIN);
    assign push       = in_valid && in_ready && !flush;

    assign dc_req_valid = head_avail && !head_mis;
    assign dc_req_store = head_store;
    assign dc_req_addr  = head_addr;
    assign dc_req_data  = head_data;
    assign dc_req_size  = head_size;
    assign dc_req_sext  = head_sext;
    assign dc_req_tag   = head_tag;

    assign issue_fire = dc_req_valid && dc_req_ready;
    assign trap_fire  = head_avail && head_mis;
    assign pop        = (issue_fire || trap_fire) && !flush;
    assign resp_match = dc_resp_valid && (dc_resp_tag == ld_tag_reg);

    assign busy      = (count_reg != '0) || (state_reg != IDLE);
    assign cmp_valid = cmp_valid_reg;
    assign cmp_tag   = cmp_tag_reg;
    assign cmp_data  = cmp_data_reg;
    assign cmp_store = cmp_store_reg;
    assign cmp_exc   = cmp_exc_reg;

    // Queue storage: write-only on push, no reset needed for payload.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= in_entry;
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Issue FSM and registered completion outputs (cleared every idle cycle).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            ld_tag_reg    <= '0;
            cmp_valid_reg <= 1'b0;
            cmp_tag_reg   <= '0;
            cmp_data_reg  <= '0;
            cmp_store_reg <= 1'b0;
            cmp_exc_reg   <= 1'b0;
        end else begin
            cmp_valid_reg <= 1'b0;
            cmp_tag_reg   <= '0;
            cmp_data_reg  <= '0;
            cmp_store_reg <= 1'b0;
            cmp_exc_reg   <= 1'b0;
            if (flush) begin
                // No completions in a flush cycle; an orphaned load must drain.
                case (state_reg)
                    WAIT, DRAIN: state_reg <= resp_match ? IDLE : DRAIN;
                    default: begin
                        if (issue_fire && !head_store) begin
                            ld_tag_reg <= head_tag;
                            state_reg  <= DRAIN;
                        end
                    end
                endcase
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (trap_fire) begin
                            cmp_valid_reg <= 1'b1;
                            cmp_tag_reg   <= head_tag;
                            cmp_store_reg <= head_store;
                            cmp_exc_reg   <= 1'b1;
                        end else if (issue_fire) begin
                            if (head_store) begin
                                cmp_valid_reg <= 1'b1;
                                cmp_tag_reg   <= head_tag;
                                cmp_store_reg <= 1'b1;
                            end else begin
                                ld_tag_reg <= head_tag;
                                state_reg  <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (resp_match) begin
                            cmp_valid_reg <= 1'b1;
                            cmp_tag_reg   <= ld_tag_reg;
                            cmp_data_reg  <= dc_resp_data;
                            state_reg     <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (resp_match)
                            state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ldst_issue_ctrl.md
Name: ldst_issue_ctrl

Overview:
In-order issue controller between dispatch and the data cache for load/store ops. Buffers ld/st ops (effective address and store data already resolved) in a DEPTH-entry FIFO. Issues them one at a time to the D$ request port with a valid/ready handshake and tracks the single outstanding load. Reports completion (load data or store done) to the ROB by tag, and supports pipeline flush.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, op queue entries (power of 2, ≥2)
TAG_W, 6, OoO/ROB tag width

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  dispatch offers op
in_ready  output  1  queue can accept (count < DEPTH)
in_opcode  input  5  bit3: 0 = load, 1 = store
in_ld_st_type  input  4  [1:0] size (0 = B, 1 = H, 2 = W, 3 = illegal → treated as W); [2] unsigned (load sext = ~[2]); [3] reserved
in_rs1  input  XLEN  effective address
in_rs2  input  XLEN  store data
in_tag  input  TAG_W  ROB tag
flush  input  1  kill all queued/in-flight ops
dc_req_valid  output  1  D$ request valid
dc_req_ready  input  1  D$ accepts
dc_req_store  output  1  1 = store
dc_req_addr  output  XLEN  address
dc_req_data  output  XLEN  store data
dc_req_size  output  2  access size
dc_req_sext  output  1  load sign-extend
dc_req_tag  output  TAG_W  tag
dc_resp_valid  input  1  load data return
dc_resp_tag  input  TAG_W  return tag
dc_resp_data  input  XLEN  return data
cmp_valid  output  1  completion pulse (1 cycle)
cmp_tag  output  TAG_W  completed tag
cmp_data  output  XLEN  load data; 0 for stores
cmp_store  output  1  completed op was a store
cmp_exc  output  1  misaligned exception
busy  output  1  queue non-empty or state ≠ IDLE

Behaviour:
- Reset (rst = 0, async): queue empty, rd/wr pointers 0, state IDLE, all cmp_* = 0, dc_req_valid = 0, busy = 0.
- Enqueue: in_valid && in_ready at edge N writes the tail. in_ready = (count < DEPTH); no full-queue bypass, so a simultaneous pop does not raise in_ready in that cycle. Pointers wrap modulo DEPTH.
- FSM states IDLE, WAIT, DRAIN.
- IDLE: dc_req_* driven combinationally from the head; dc_req_valid = (count ≠ 0). Request fields hold stable while valid && !ready.
  - Handshake on a store: pop; cmp_valid = 1 at N+1 with cmp_store = 1 and cmp_data = 0; stay IDLE.
  - Handshake on a load: pop; latch tag; go to WAIT.
- WAIT: dc_req_valid = 0. On dc_resp_valid && dc_resp_tag == latched tag: cmp_valid = 1 next cycle with cmp_data = dc_resp_data; go to IDLE. Responses with a non-matching tag are ignored.
- Throughput: back-to-back stores sustain 1 per cycle. A load blocks issue until its response completes.
- flush (priority over enqueue, issue and response in the same cycle): count → 0 and pointers reset. An in-flight handshake in the flush cycle produces no completion.
  - From WAIT, or from a load handshake in the flush cycle: go to DRAIN.
  - From IDLE: stay IDLE.
- DRAIN: dc_req_valid = 0; in_ready = 0. The matching response is discarded (no cmp). Then go to IDLE.
- A response arriving in the same cycle as flush is discarded; go to IDLE, not DRAIN.
- cmp_* are registered outputs, cleared to 0 in any cycle without a completion.

Optional Feature:
LDST_MISALIGN_TRAP_EN
- Defined: at the IDLE head, an op is misaligned if (H && addr[0]) or (W && addr[1:0] ≠ 0). The op is not sent to the D$ (dc_req_valid = 0 for it). It is popped, and one cycle later cmp_valid = 1, cmp_exc = 1, cmp_data = 0, with cmp_store reflecting the op type. Issue of the next op resumes the following cycle.
- Undefined: no check; all ops issue; cmp_exc tied to 0.

Test Plan:
- Reset mid-WAIT: load tag 5 accepted by D$, assert rst = 0 → same cycle state IDLE, busy = 0, cmp_valid = 0; a later resp tag 5 produces no cmp.
- Store stream: 4 stores (tags 1–4, addr 0x100..0x10C, dc_req_ready = 1) → dc_req_valid on 4 consecutive cycles, cmp_valid 4 consecutive cycles with tags 1–4, cmp_store = 1; after the 4th enqueue with no pop, in_ready = 0.
- Load, then store: load tag 7 addr 0x200 LW; resp tag 7 data 0xDEADBEEF 3 cycles later → cmp tag 7 data 0xDEADBEEF the next cycle; the store issues only after WAIT exits.
- Backpressure: dc_req_ready = 0 for 5 cycles with a LB head (type 0) → dc_req_valid and all fields stable, dc_req_sext = 1; LBU (type 4) → sext = 0.
- Flush in WAIT: load tag 3 outstanding with 2 ops queued, flush → count 0, state DRAIN, in_ready = 0; resp tag 3 → no cmp, then IDLE.
- With LDST_MISALIGN_TRAP_EN: LW addr 0x102 tag 9 → no dc_req_valid, cmp tag 9 cmp_exc = 1; without the macro, the same op issues with addr 0x102.
